// File: rtl/lift_pkg.sv
// Shared types and floor helpers for the three-floor lift controller.
package lift_pkg;

   localparam int N_FLOOR = 3;

   localparam logic [1:0] FLOOR_NONE = 2'd0;
   localparam logic [1:0] FLOOR_BOT  = 2'd1;
   localparam logic [1:0] FLOOR_TOP  = 2'd3;

   typedef enum logic [2:0] {
      ST_HOMING,
      ST_IDLE,
      ST_MOVE_UP,
      ST_MOVE_DOWN,
      ST_DOOR,
      ST_FAULT
   } lift_state_t;

   // One-hot bit for a floor number; unknown floor maps to no bit.
   function automatic logic [N_FLOOR-1:0] floor_mask(input logic [1:0] f);
      case (f)
         2'd1:    floor_mask = 3'b001;
         2'd2:    floor_mask = 3'b010;
         2'd3:    floor_mask = 3'b100;
         default: floor_mask = 3'b000;
      endcase
   endfunction

   // Floors strictly above the given floor.
   function automatic logic [N_FLOOR-1:0] above_mask(input logic [1:0] f);
      case (f)
         2'd1:    above_mask = 3'b110;
         2'd2:    above_mask = 3'b100;
         default: above_mask = 3'b000;
      endcase
   endfunction

   // Floors strictly below the given floor.
   function automatic logic [N_FLOOR-1:0] below_mask(input logic [1:0] f);
      case (f)
         2'd2:    below_mask = 3'b001;
         2'd3:    below_mask = 3'b011;
         default: below_mask = 3'b000;
      endcase
   endfunction

   // Floor number of a single-bit sensor vector.
   function automatic logic [1:0] mask_floor(input logic [N_FLOOR-1:0] m);
      case (m)
         3'b001:  mask_floor = 2'd1;
         3'b010:  mask_floor = 2'd2;
         3'b100:  mask_floor = 2'd3;
         default: mask_floor = FLOOR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Reset preloads the count so a freshly reset watchdog starts a full interval.
module lift_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count;

   // Clear beats load so a timer parked outside its state stays at zero.
   always_ff @(posedge clk) begin
      if (rst)
         count <= load_value;
      else if (clear)
         count <= '0;
      else if (load)
         count <= load_value;
      else if (count != '0)
         count <= count - WIDTH'(1);
   end

   assign done = (count == '0);

endmodule

// File: rtl/lift_ctrl.sv
// Three-floor lift car controller: homing, call latching, travel, door dwell
// and a travel watchdog, all outputs registered from the next-state decode.
module lift_ctrl
   import lift_pkg::*;
#(
   parameter int DOOR_CYCLES  = 1000,
   parameter int MOVE_TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] arrive,
   input  logic [2:0] leave,
   input  logic [2:0] call,
   output logic [2:0] call_pending,
   output logic [1:0] floor,
   output logic       motor_up,
   output logic       motor_down,
   output logic       door_open,
   output logic       fault
);

   localparam int DOOR_W = $clog2(DOOR_CYCLES);
   localparam int WD_W   = $clog2(MOVE_TIMEOUT);

   lift_state_t state, next_state;
   logic [1:0]  next_floor;
   logic [2:0]  pend_next;
   logic        dir_up;

   logic [2:0]  call_eff;
   logic [2:0]  pend_in;
   logic [2:0]  clear_mask;
   logic [1:0]  up_floor;
   logic [1:0]  dn_floor;
   logic        arr_multi;
   logic        pulse;

   logic        door_load;
   logic        door_done;
   logic        wd_load;
   logic        wd_clear;
   logic        wd_done;

   // Next state, next floor and next call lamps from the current state and inputs.
   always_comb begin
      next_state = state;
      next_floor = floor;
      clear_mask = 3'b000;
      arr_multi  = ((arrive & (arrive - 3'd1)) != 3'd0);
      pulse      = (|arrive) | (|leave);
      up_floor   = floor + 2'd1;
      dn_floor   = floor - 2'd1;
      call_eff   = call;
      if (state == ST_IDLE || state == ST_DOOR)
         call_eff = call & ~floor_mask(floor);
      pend_in = call_pending | call_eff;

      case (state)
         ST_HOMING: begin
            if (arr_multi)
               next_state = ST_FAULT;
            else if (|arrive) begin
               next_floor = mask_floor(arrive);
               next_state = ST_DOOR;
            end else if (wd_done && !pulse)
               next_state = ST_FAULT;
         end
         ST_IDLE: begin
            if (pulse)
               next_state = ST_FAULT;
            else if (|(call_pending & floor_mask(floor)))
               next_state = ST_DOOR;
            else if (|(call_pending & above_mask(floor)) &&
                     (dir_up || !(|(call_pending & below_mask(floor)))))
               next_state = ST_MOVE_UP;
            else if (|(call_pending & below_mask(floor)))
               next_state = ST_MOVE_DOWN;
         end
         ST_MOVE_UP: begin
            if (arr_multi || (|(arrive & ~floor_mask(up_floor))) ||
                (|(leave & ~floor_mask(floor))))
               next_state = ST_FAULT;
            else if (|arrive) begin
               next_floor = up_floor;
               if ((|(pend_in & floor_mask(up_floor))) || up_floor == FLOOR_TOP)
                  next_state = ST_DOOR;
            end else if (wd_done && !pulse)
               next_state = ST_FAULT;
         end
         ST_MOVE_DOWN: begin
            if (arr_multi || (|(arrive & ~floor_mask(dn_floor))) ||
                (|(leave & ~floor_mask(floor))))
               next_state = ST_FAULT;
            else if (|arrive) begin
               next_floor = dn_floor;
               if ((|(pend_in & floor_mask(dn_floor))) || dn_floor == FLOOR_BOT)
                  next_state = ST_DOOR;
            end else if (wd_done && !pulse)
               next_state = ST_FAULT;
         end
         ST_DOOR: begin
            if (pulse)
               next_state = ST_FAULT;
            else if (door_done)
               next_state = ST_IDLE;
         end
         ST_FAULT: next_state = ST_FAULT;
         default:  next_state = ST_FAULT;
      endcase

      if (next_state == ST_DOOR && state != ST_DOOR)
         clear_mask = floor_mask(next_floor);
      pend_next = pend_in & ~clear_mask;
   end

   assign door_load = (next_state == ST_DOOR) && (state != ST_DOOR);
   assign wd_load   = (next_state != state) || pulse;
   assign wd_clear  = !(next_state == ST_HOMING || next_state == ST_MOVE_UP ||
                        next_state == ST_MOVE_DOWN);

   lift_timer #(.WIDTH(DOOR_W)) u_door_timer (
      .clk        (clk),
      .rst        (rst),
      .clear      (1'b0),
      .load       (door_load),
      .load_value (DOOR_W'(DOOR_CYCLES - 1)),
      .done       (door_done)
   );

   lift_timer #(.WIDTH(WD_W)) u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .clear      (wd_clear),
      .load       (wd_load),
      .load_value (WD_W'(MOVE_TIMEOUT - 1)),
      .done       (wd_done)
   );

   // State register with outputs decoded from the next state so they are registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_HOMING;
         floor        <= FLOOR_NONE;
         call_pending <= 3'b000;
         dir_up       <= 1'b1;
         motor_up     <= 1'b0;
         motor_down   <= 1'b0;
         door_open    <= 1'b0;
         fault        <= 1'b0;
      end else begin
         state        <= next_state;
         floor        <= next_floor;
         call_pending <= pend_next;
         if (next_state == ST_MOVE_UP)
            dir_up <= 1'b1;
         else if (next_state == ST_MOVE_DOWN)
            dir_up <= 1'b0;
         motor_up     <= (next_state == ST_MOVE_UP);
         motor_down   <= (next_state == ST_MOVE_DOWN) || (next_state == ST_HOMING);
         door_open    <= (next_state == ST_DOOR);
         fault        <= (next_state == ST_FAULT);
      end
   end

endmodule

// File: tb/tb_lift_ctrl.sv
// Scoreboard bench for lift_ctrl: stimulus queues edge-stamped expected outputs,
// a negedge monitor pops and compares them as the DUT reaches each edge.
module tb_lift_ctrl;

   logic       clk;
   logic       rst;
   logic [2:0] arrive;
   logic [2:0] leave;
   logic [2:0] call;
   logic [2:0] call_pending;
   logic [1:0] floor;
   logic       motor_up;
   logic       motor_down;
   logic       door_open;
   logic       fault;

   int cyc   = 0;
   int total = 0;
   int bad   = 0;

   int         q_edge[$];
   string      q_name[$];
   logic [8:0] q_val[$];

   lift_ctrl #(.DOOR_CYCLES(3), .MOVE_TIMEOUT(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .arrive       (arrive),
      .leave        (leave),
      .call         (call),
      .call_pending (call_pending),
      .floor        (floor),
      .motor_up     (motor_up),
      .motor_down   (motor_down),
      .door_open    (door_open),
      .fault        (fault)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count rising edges so expectations can be stamped with an edge number.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic expectOutput(input int ofs, input string nm, input logic [2:0] cp,
                               input logic [1:0] fl, input logic up, input logic dn,
                               input logic dr, input logic ft);
      q_edge.push_back(cyc + ofs);
      q_name.push_back(nm);
      q_val.push_back({cp, fl, up, dn, dr, ft});
   endtask

   task automatic checkOutput(input string nm, input int edge_no, input logic [8:0] want);
      logic [8:0] got;
      got = {call_pending, floor, motor_up, motor_down, door_open, fault};
      total++;
      if (edge_no != cyc || got !== want) begin
         bad++;
         $display("[TB] FAIL %s edge=%0d/%0d got cp=%b fl=%0d up=%b dn=%b door=%b flt=%b want cp=%b fl=%0d up=%b dn=%b door=%b flt=%b",
                  nm, cyc, edge_no, got[8:6], got[5:4], got[3], got[2], got[1], got[0],
                  want[8:6], want[5:4], want[3], want[2], want[1], want[0]);
      end
   endtask

   // Monitor: compare every queued expectation whose edge has been reached.
   always @(negedge clk) begin
      while (q_edge.size() > 0 && q_edge[0] <= cyc) begin
         checkOutput(q_name[0], q_edge[0], q_val[0]);
         void'(q_edge.pop_front());
         void'(q_name.pop_front());
         void'(q_val.pop_front());
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [2:0] a, input logic [2:0] l, input logic [2:0] c);
      arrive = a;
      leave  = l;
      call   = c;
      @(negedge clk);
      arrive = 3'b000;
      leave  = 3'b000;
      call   = 3'b000;
   endtask

   task automatic tripDownToOne(input string tag);
      expectOutput(1, {tag, "_call1"},  3'b001, 2'd3, 0, 0, 0, 0);
      expectOutput(2, {tag, "_start"},  3'b001, 2'd3, 0, 1, 0, 0);
      applyStimulus(3'b000, 3'b000, 3'b001);
      waitCycles(1);
      expectOutput(1, {tag, "_pass2"},  3'b001, 2'd2, 0, 1, 0, 0);
      applyStimulus(3'b010, 3'b000, 3'b000);
      expectOutput(1, {tag, "_stop1"},  3'b000, 2'd1, 0, 0, 1, 0);
      expectOutput(4, {tag, "_idle1"},  3'b000, 2'd1, 0, 0, 0, 0);
      applyStimulus(3'b001, 3'b000, 3'b000);
      waitCycles(3);
   endtask

   // Directed scenario sequence.
   initial begin
      rst    = 1'b1;
      arrive = 3'b000;
      leave  = 3'b000;
      call   = 3'b000;

      // Reset and homing.
      expectOutput(2, "reset_state", 3'b000, 2'd0, 0, 0, 0, 0);
      waitCycles(3);
      rst = 1'b0;
      expectOutput(1,  "homing_down", 3'b000, 2'd0, 0, 1, 0, 0);
      expectOutput(19, "homing_wait", 3'b000, 2'd0, 0, 1, 0, 0);
      waitCycles(20);
      expectOutput(1, "homed_door",  3'b000, 2'd1, 0, 0, 1, 0);
      expectOutput(3, "door_last",   3'b000, 2'd1, 0, 0, 1, 0);
      expectOutput(4, "homed_idle",  3'b000, 2'd1, 0, 0, 0, 0);
      applyStimulus(3'b001, 3'b000, 3'b000);
      waitCycles(3);

      // Single call to floor 3, passing floor 2.
      expectOutput(1, "call_latch",    3'b100, 2'd1, 0, 0, 0, 0);
      expectOutput(2, "call_to_motor", 3'b100, 2'd1, 1, 0, 0, 0);
      applyStimulus(3'b000, 3'b000, 3'b100);
      waitCycles(1);
      expectOutput(1, "leave1_legal",  3'b100, 2'd1, 1, 0, 0, 0);
      applyStimulus(3'b000, 3'b001, 3'b000);
      expectOutput(1, "pass_floor2",   3'b100, 2'd2, 1, 0, 0, 0);
      applyStimulus(3'b010, 3'b000, 3'b000);
      expectOutput(1, "stop_floor3",   3'b000, 2'd3, 0, 0, 1, 0);
      expectOutput(4, "idle_floor3",   3'b000, 2'd3, 0, 0, 0, 0);
      applyStimulus(3'b100, 3'b000, 3'b000);
      waitCycles(3);

      tripDownToOne("trip1");

      // Call at the floor the idle car already sits on is ignored.
      expectOutput(1, "call_here_ignored", 3'b000, 2'd1, 0, 0, 0, 0);
      applyStimulus(3'b000, 3'b000, 3'b001);

      // Intermediate pickup at floor 2 on the way up.
      expectOutput(1, "pickup_call3",  3'b100, 2'd1, 0, 0, 0, 0);
      expectOutput(2, "pickup_up",     3'b100, 2'd1, 1, 0, 0, 0);
      applyStimulus(3'b000, 3'b000, 3'b100);
      waitCycles(1);
      expectOutput(1, "pickup_latch2", 3'b110, 2'd1, 1, 0, 0, 0);
      applyStimulus(3'b000, 3'b000, 3'b010);
      expectOutput(1, "pickup_stop2",  3'b100, 2'd2, 0, 0, 1, 0);
      expectOutput(4, "pickup_idle2",  3'b100, 2'd2, 0, 0, 0, 0);
      expectOutput(5, "pickup_resume", 3'b100, 2'd2, 1, 0, 0, 0);
      applyStimulus(3'b010, 3'b000, 3'b000);
      waitCycles(4);
      expectOutput(1, "pickup_stop3",  3'b000, 2'd3, 0, 0, 1, 0);
      expectOutput(4, "pickup_idle3",  3'b000, 2'd3, 0, 0, 0, 0);
      applyStimulus(3'b100, 3'b000, 3'b000);
      waitCycles(3);

      tripDownToOne("trip2");

      // Call and arrival for floor 2 on the same edge.
      expectOutput(1, "sc_call3",     3'b100, 2'd1, 0, 0, 0, 0);
      expectOutput(2, "sc_up",        3'b100, 2'd1, 1, 0, 0, 0);
      applyStimulus(3'b000, 3'b000, 3'b100);
      waitCycles(1);
      expectOutput(1, "sc_stop2",     3'b100, 2'd2, 0, 0, 1, 0);
      expectOutput(2, "sc_lamp_off",  3'b100, 2'd2, 0, 0, 1, 0);
      expectOutput(4, "sc_idle2",     3'b100, 2'd2, 0, 0, 0, 0);
      expectOutput(5, "sc_resume",    3'b100, 2'd2, 1, 0, 0, 0);
      applyStimulus(3'b010, 3'b000, 3'b010);
      waitCycles(4);

      // Reset while moving up.
      rst = 1'b1;
      expectOutput(1, "rst_midmove", 3'b000, 2'd0, 0, 0, 0, 0);
      expectOutput(2, "rehome",      3'b000, 2'd0, 0, 1, 0, 0);
      waitCycles(1);
      rst = 1'b0;
      waitCycles(1);
      expectOutput(1, "rehomed_door", 3'b000, 2'd1, 0, 0, 1, 0);
      expectOutput(4, "rehomed_idle", 3'b000, 2'd1, 0, 0, 0, 0);
      applyStimulus(3'b001, 3'b000, 3'b000);
      waitCycles(3);

      // Skipping floor 2 on the way up is a sensor fault.
      expectOutput(1, "f_call3", 3'b100, 2'd1, 0, 0, 0, 0);
      expectOutput(2, "f_up",    3'b100, 2'd1, 1, 0, 0, 0);
      applyStimulus(3'b000, 3'b000, 3'b100);
      waitCycles(1);
      expectOutput(1,  "fault_skip_floor", 3'b100, 2'd1, 0, 0, 0, 1);
      expectOutput(10, "fault_sticky",     3'b100, 2'd1, 0, 0, 0, 1);
      applyStimulus(3'b100, 3'b000, 3'b000);
      waitCycles(9);

      // Reset clears the fault; homing with no sensor pulse trips the watchdog.
      rst = 1'b1;
      expectOutput(1, "rst_clears_fault", 3'b000, 2'd0, 0, 0, 0, 0);
      expectOutput(2, "wd_homing",        3'b000, 2'd0, 0, 1, 0, 0);
      waitCycles(1);
      rst = 1'b0;
      expectOutput(31, "wd_not_yet", 3'b000, 2'd0, 0, 1, 0, 0);
      expectOutput(32, "wd_fault",   3'b000, 2'd0, 0, 0, 0, 1);
      waitCycles(34);

      while (q_edge.size() > 0) begin
         total++;
         bad++;
         $display("[TB] FAIL %s never checked edge=%0d now=%0d", q_name[0], q_edge[0], cyc);
         void'(q_edge.pop_front());
         void'(q_name.pop_front());
         void'(q_val.pop_front());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lift_ctrl.md
# lift_ctrl

Three-floor elevator car controller sitting directly downstream of the infrared sensor edge detector. Consumes its one-cycle per-floor beam edge pulses plus hall/car call pulses. Tracks the car position, latches and serves calls, and drives the motor and door outputs through a Moore state machine with a door dwell timer and a travel watchdog.

## Interface
- `DOOR_CYCLES`, default 1000: clock cycles the door stays open per stop (≥2).
- `MOVE_TIMEOUT`, default 50000: maximum cycles allowed between consecutive sensor events while moving (≥2).
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `arrive`  in  3  one-cycle pulses. Bit i = car beam broken at floor i+1 (falling-edge pulse of sensor i+1).
- `leave`  in  3  one-cycle pulses. Bit i = car cleared floor i+1 (rising-edge pulse of sensor i+1).
- `call`  in  3  one-cycle call button pulses. Bit i = request for floor i+1.
- `call_pending`  out  3  latched, unserved calls (button lamps).
- `floor`  out  2  current/last floor, 1..3; 0 = unknown.
- `motor_up`  out  1  drive car upward.
- `motor_down`  out  1  drive car downward.
- `door_open`  out  1  door actuator.
- `fault`  out  1  sticky fault indicator.

## Operation
- **Reset values:**
  - `call_pending`=0, `floor`=0, `motor_up`=0, `door_open`=0, `fault`=0, `motor_down`=0.
  - State enters HOMING on the first cycle after reset. HOMING drives `motor_down`=1.
  - Reset asserted mid-move drops both motor outputs on the next edge.
- **States:** HOMING, IDLE, MOVE_UP, MOVE_DOWN, DOOR, FAULT. All outputs are registered.
- **HOMING:** `motor_down`=1 until any `arrive` bit. Then `floor` is set to that floor and the state goes to DOOR.
- **Call latching:**
  - `call[i]` sets `call_pending[i]`. It is ignored if the car is stationary (IDLE or DOOR) at floor i+1.
  - `call_pending[i]` clears when DOOR is entered at floor i+1.
- **IDLE:** selection follows a direction preference held in a register (`dir_up`, reset 1).
  - Any pending call at the current floor → DOOR.
  - Else a call above and (`dir_up` or none below) → MOVE_UP.
  - Else a call below → MOVE_DOWN.
  - Else stay in IDLE.
- **MOVE_UP / MOVE_DOWN:** motor bit asserted, `dir_up` updated.
  - The only legal arrival is `floor`+1 (up) or `floor`−1 (down). It updates `floor`.
  - The car stops (→DOOR) if that floor has a pending call, including one latched in the same cycle, or is the end floor (3 up, 1 down). Otherwise it keeps moving.
  - The only legal `leave` is the current `floor`.
- **DOOR:** `door_open`=1 for exactly DOOR_CYCLES cycles, then IDLE.
- **FAULT:** all motor and door outputs 0, `fault`=1. Exit is by reset only. FAULT is entered on:
  - an illegal `arrive`/`leave` bit in any state;
  - any `leave` in IDLE/DOOR;
  - more than one `arrive` bit at once;
  - a watchdog expiry: MOVE_TIMEOUT cycles without any sensor pulse in HOMING/MOVE_*.
- `motor_up` and `motor_down` are never both 1, which is structurally guaranteed by the state decode.

## Timing
- `call` pulse sampled at edge t → `call_pending` high after t.
- IDLE with a pending call at edge t+1 → `motor_*` high after t+1, for a call-to-motor latency of 2 cycles.
- `arrive` sampled at edge k, stop floor → `floor` updated, motor low, `door_open` high, call cleared, all after k.
- `door_open` is high for DOOR_CYCLES edges. IDLE re-evaluates on the first cycle after it falls.
- The watchdog counter clears on every `arrive`/`leave` pulse and on state entry. The fault is registered on the edge the count reaches MOVE_TIMEOUT.
- Simultaneous `call[i]` and arrival at floor i+1 while moving: the car stops and `call_pending[i]` stays 0.

## Structure
- Package `lift_pkg` holds:
  - the state enum;
  - the floor encoding constants: `FLOOR_NONE`=0, `FLOOR_TOP`=3, `FLOOR_BOT`=1;
  - `N_FLOOR`=3.
- Sub-module `lift_timer`: a loadable down-counter with clear and a `done` output. It is instantiated twice, for the door dwell and the travel watchdog.

## Test plan
- **Reset/homing:** reset, then `arrive`=001 after 20 cycles → `motor_down` 1 during wait; then `floor`=1, DOOR for DOOR_CYCLES, then IDLE with all outputs 0.
- **Single call:** at floor 1 idle, `call`=100 → `motor_up` 2 cycles later. Pulse `leave`=001, `arrive`=010 → no stop, `floor`=2. Pulse `arrive`=100 → stop, `floor`=3, `door_open`, `call_pending`=000.
- **Intermediate pickup:** moving up from 1 toward 3, `call`=010 issued before `arrive`=010 → car stops at 2, then resumes up to 3 after the door cycle.
- **Same-cycle call/arrival:** `call[1]` and `arrive[1]` on the same edge while moving up → stop at 2; `call_pending[1]` never observed high.
- **Faults:**
  - moving up from 1, `arrive`=100 → `fault`=1 next cycle, motors 0, stays until `rst`;
  - a separate run with no sensor pulses for MOVE_TIMEOUT cycles → `fault`=1.
- **Reset mid-move:** assert `rst` during MOVE_UP → motors 0 and `floor`=0 on the next edge; HOMING after release.
